// File: rtl/block_pattern_gen.sv
// block_pattern_gen: burst generator of BITS_BLOCK-wide transcoded test blocks
//   (cyclic k=1..4, transfer-index counter, PRBS31 x^31+x^28+1, idle fill).
// Latency: first o_valid one cycle after i_start is sampled in IDLE; o_block is registered.
// Backpressure: a transfer happens when o_valid && i_ready; while i_ready=0 o_block holds.
//
// Ports:
//   clk           - single clock
//   rst           - synchronous active-high reset (takes priority over i_start)
//   i_start       - burst request, sampled only in IDLE
//   i_mode        - pattern select (0 cyclic, 1 counter, 2 PRBS31, 3 idle), latched at start
//   i_num_blocks  - burst length, latched at start (0 = empty burst, straight to DONE)
//   i_ready       - downstream ready
//   o_block       - generated block, bit 0 is the header bit
//   o_valid       - o_block valid (RUN only)
//   o_busy        - high while in RUN
//   o_done        - one-cycle burst-complete pulse
//   o_count       - blocks transferred in the current or last burst
module block_pattern_gen #(
  parameter int BITS_BLOCK = 257,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [1:0]            i_mode,
  input  logic [CNT_WIDTH-1:0]  i_num_blocks,
  input  logic                  i_ready,
  output logic [BITS_BLOCK-1:0] o_block,
  output logic                  o_valid,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [CNT_WIDTH-1:0]  o_count
);

  localparam int PAY_W = BITS_BLOCK - 1;
  // Number of 3-bit copies needed to cover the block in cyclic mode.
  localparam int REPS = (BITS_BLOCK + 2) / 3;
  localparam logic [30:0] PRBS_SEED = 31'h7FFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [1:0]            r_mode;
  logic [CNT_WIDTH-1:0]  r_len;
  logic [CNT_WIDTH-1:0]  r_count;
  logic [2:0]            r_cyc_k;
  logic [30:0]           r_prbs;
  logic [BITS_BLOCK-1:0] r_block;

  logic                  w_idle;
  logic                  w_xfer;
  logic                  w_last;
  logic                  w_len_zero;
  logic [CNT_WIDTH-1:0]  w_count_inc;
  logic [2:0]            w_k_adv;

  // Parameters of the block to be loaded next: taken from the inputs when a
  // burst is being started, from the latched/running state otherwise.
  logic [1:0]            w_sel_mode;
  logic [2:0]            w_sel_k;
  logic [CNT_WIDTH-1:0]  w_sel_idx;
  logic [30:0]           w_gen_state;

  logic [BITS_BLOCK-1:0] w_cyc_blk;
  logic [PAY_W-1:0]      w_cnt_pay;
  logic [PAY_W-1:0]      w_prbs_pay;
  logic [30:0]           w_prbs_nxt;
  logic [BITS_BLOCK-1:0] w_next_block;

  assign w_idle      = (r_state == S_IDLE);
  assign w_xfer      = (r_state == S_RUN) && i_ready;
  assign w_count_inc = r_count + CNT_WIDTH'(1);
  // Compare against the incremented count so the transfer that reaches the
  // length is the one that ends the burst; works up to 2^CNT_WIDTH-1.
  assign w_last      = (w_count_inc == r_len);
  assign w_len_zero  = (i_num_blocks == '0);
  assign w_k_adv     = (r_cyc_k == 3'd4) ? 3'd1 : (r_cyc_k + 3'd1);

  assign w_sel_mode  = w_idle ? i_mode    : r_mode;
  assign w_sel_k     = w_idle ? 3'd1      : w_k_adv;
  assign w_sel_idx   = w_idle ? '0        : w_count_inc;
  assign w_gen_state = w_idle ? PRBS_SEED : r_prbs;

  // Cyclic pattern: 3-bit k replicated, truncated to the block width.
  assign w_cyc_blk = BITS_BLOCK'({REPS{w_sel_k}});

  // Counter pattern: transfer index zero-extended into the payload.
  assign w_cnt_pay = PAY_W'(w_sel_idx);

  // PRBS31 Fibonacci LFSR. The emitted bit is the oldest state bit, so the
  // first 31 bits out of the all-ones seed are the seed itself. Bits are
  // shifted in from the top, leaving the earliest bit at payload bit 0.
  always_comb begin
    logic [30:0] lfsr;
    lfsr       = w_gen_state;
    w_prbs_pay = '0;
    for (int i = 0; i < PAY_W; i++) begin
      w_prbs_pay = {lfsr[30], w_prbs_pay[PAY_W-1:1]};
      lfsr       = {lfsr[29:0], lfsr[30] ^ lfsr[27]};
    end
    w_prbs_nxt = lfsr;
  end

  always_comb begin
    w_next_block = '0;
    case (w_sel_mode)
      2'd0:    w_next_block = w_cyc_blk;
      2'd1:    w_next_block = {w_cnt_pay, 1'b1};
      2'd2:    w_next_block = {w_prbs_pay, 1'b1};
      default: w_next_block = {{PAY_W{1'b0}}, 1'b1};
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = w_len_zero ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_xfer && w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    o_valid = 1'b0;
    o_busy  = 1'b0;
    o_done  = 1'b0;
    case (r_state)
      S_RUN: begin
        o_valid = 1'b1;
        o_busy  = 1'b1;
      end
      S_DONE:  o_done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: latch burst parameters at start, advance generators per transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode  <= 2'd0;
      r_len   <= '0;
      r_count <= '0;
      r_cyc_k <= 3'd0;
      r_prbs  <= PRBS_SEED;
      r_block <= '0;
    end else if (w_idle && i_start) begin
      r_mode  <= i_mode;
      r_len   <= i_num_blocks;
      r_count <= '0;
      if (!w_len_zero) begin
        r_block <= w_next_block;
        r_cyc_k <= 3'd1;
        r_prbs  <= w_prbs_nxt;
      end
    end else if (w_xfer) begin
      r_count <= w_count_inc;
      r_block <= w_next_block;
      r_cyc_k <= w_k_adv;
      r_prbs  <= w_prbs_nxt;
    end
  end

  assign o_block = r_block;
  assign o_count = r_count;

endmodule

// File: tb/tb_block_pattern_gen.sv
// Directed bench for block_pattern_gen: reset, cyclic, counter with stalls,
// PRBS31, empty burst, mid-burst reset, start during RUN, long idle-fill burst.
// Inputs are driven and outputs sampled 1ns after each rising edge.
`timescale 1ns/1ps
module tb_block_pattern_gen;
  localparam int BB   = 257;
  localparam int CW   = 8;
  localparam int PW   = BB - 1;
  localparam int REPS = (BB + 2) / 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic [1:0]    i_mode;
  logic [CW-1:0] i_num_blocks;
  logic          i_ready;
  logic [BB-1:0] o_block;
  logic          o_valid;
  logic          o_busy;
  logic          o_done;
  logic [CW-1:0] o_count;

  int n_tests = 0;
  int n_fail  = 0;
  bit prbs_ref [0:1023];

  always #5 clk = ~clk;

  block_pattern_gen #(.BITS_BLOCK(BB), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_mode       (i_mode),
    .i_num_blocks (i_num_blocks),
    .i_ready      (i_ready),
    .o_block      (o_block),
    .o_valid      (o_valid),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_count      (o_count)
  );

  function automatic logic [BB-1:0] exp_cyc(input int k);
    logic [2:0]        k3;
    logic [3*REPS-1:0] rep;
    k3  = k[2:0];
    rep = {REPS{k3}};
    return rep[BB-1:0];
  endfunction

  function automatic logic [BB-1:0] exp_cnt(input int idx);
    logic [BB-1:0] b;
    b       = '0;
    b[0]    = 1'b1;
    b[CW:1] = idx[CW-1:0];
    return b;
  endfunction

  function automatic logic [BB-1:0] exp_prbs(input int j);
    logic [BB-1:0] b;
    b    = '0;
    b[0] = 1'b1;
    for (int i = 0; i < PW; i++) b[i+1] = prbs_ref[j*PW + i];
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a burst, then scramble mode/length to show they are latched.
  task automatic do_start(input int mode, input int num);
    i_mode       = mode[1:0];
    i_num_blocks = num[CW-1:0];
    i_start      = 1'b1;
    tick();
    i_start      = 1'b0;
    i_mode       = ~mode[1:0];
    i_num_blocks = num[CW-1:0] ^ 8'h5A;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_start = 1'b1; i_mode = 2'd1; i_num_blocks = 8'd5; i_ready = 1'b1;
    tick(); tick();
    n_tests++;
    if ({o_valid, o_busy, o_done} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags got %b exp 000", {o_valid, o_busy, o_done});
    end
    n_tests++;
    if (o_count !== '0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", o_count); end
    n_tests++;
    if (o_block !== '0) begin n_fail++; $display("FAIL reset_block got %h exp 0", o_block); end
    i_start = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    n_tests++;
    if ({o_valid, o_busy, o_done} !== 3'b000) begin
      n_fail++; $display("FAIL reset_idle got %b exp 000", {o_valid, o_busy, o_done});
    end
  endtask

  task automatic test_cyclic();
    i_ready = 1'b1;
    do_start(0, 8);
    for (int c = 0; c < 8; c++) begin
      n_tests++;
      if ({o_valid, o_busy} !== 2'b11) begin
        n_fail++; $display("FAIL cyc_valid c=%0d got %b exp 11", c, {o_valid, o_busy});
      end
      n_tests++;
      if (o_block !== exp_cyc(c % 4 + 1)) begin
        n_fail++; $display("FAIL cyc_block c=%0d got %h exp %h", c, o_block, exp_cyc(c % 4 + 1));
      end
      n_tests++;
      if (o_count !== c[CW-1:0]) begin
        n_fail++; $display("FAIL cyc_count c=%0d got %0d exp %0d", c, o_count, c);
      end
      tick();
    end
    n_tests++;
    if ({o_valid, o_done} !== 2'b01) begin
      n_fail++; $display("FAIL cyc_done got valid,done=%b exp 01", {o_valid, o_done});
    end
    n_tests++;
    if (o_count !== 8'd8) begin n_fail++; $display("FAIL cyc_final_count got %0d exp 8", o_count); end
    tick();
    n_tests++;
    if ({o_done, o_busy, o_count} !== {2'b00, 8'd8}) begin
      n_fail++; $display("FAIL cyc_after got done=%b busy=%b count=%0d exp 0 0 8", o_done, o_busy, o_count);
    end
  endtask

  task automatic test_counter_stall();
    int idx, xfers, dones, vcyc;
    idx = 0; xfers = 0; dones = 0; vcyc = 0;
    i_ready = 1'b1;
    do_start(1, 4);
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (o_done) dones++;
      if (o_valid) begin
        n_tests++;
        if (o_block !== exp_cnt(idx)) begin
          n_fail++; $display("FAIL cnt_block vcyc=%0d got %h exp %h", vcyc, o_block, exp_cnt(idx));
        end
        i_ready = (vcyc % 2 == 0);
        if (i_ready) begin idx++; xfers++; end
        vcyc++;
      end
      tick();
    end
    i_ready = 1'b1;
    n_tests++;
    if (xfers !== 4) begin n_fail++; $display("FAIL cnt_xfers got %0d exp 4", xfers); end
    n_tests++;
    if (vcyc !== 7) begin n_fail++; $display("FAIL cnt_valid_cycles got %0d exp 7", vcyc); end
    n_tests++;
    if (dones !== 1) begin n_fail++; $display("FAIL cnt_done_pulses got %0d exp 1", dones); end
    n_tests++;
    if (o_count !== 8'd4) begin n_fail++; $display("FAIL cnt_final_count got %0d exp 4", o_count); end
  endtask

  task automatic test_prbs();
    logic [BB-1:0] blk0;
    i_ready = 1'b1;
    do_start(2, 2);
    blk0 = o_block;
    n_tests++;
    if (o_valid !== 1'b1) begin n_fail++; $display("FAIL prbs_valid got %b exp 1", o_valid); end
    n_tests++;
    if (blk0[31:0] !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL prbs_seed_bits got %h exp ffffffff", blk0[31:0]);
    end
    n_tests++;
    if ({blk0[60], blk0[59:32]} !== {1'b1, 28'h0}) begin
      n_fail++; $display("FAIL prbs_bits60_32 got %h exp 10000000", {blk0[60], blk0[59:32]});
    end
    n_tests++;
    if (blk0 !== exp_prbs(0)) begin n_fail++; $display("FAIL prbs_block0 got %h exp %h", blk0, exp_prbs(0)); end
    tick();
    n_tests++;
    if (o_block !== exp_prbs(1)) begin n_fail++; $display("FAIL prbs_block1 got %h exp %h", o_block, exp_prbs(1)); end
    tick();
    n_tests++;
    if ({o_valid, o_done} !== 2'b01) begin
      n_fail++; $display("FAIL prbs_done got valid,done=%b exp 01", {o_valid, o_done});
    end
    tick();
  endtask

  task automatic test_zero_len();
    do_start(0, 0);
    n_tests++;
    if ({o_valid, o_done} !== 2'b01) begin
      n_fail++; $display("FAIL zero_done got valid,done=%b exp 01", {o_valid, o_done});
    end
    n_tests++;
    if (o_count !== '0) begin n_fail++; $display("FAIL zero_count got %0d exp 0", o_count); end
    tick();
    n_tests++;
    if ({o_valid, o_done, o_busy} !== 3'b000) begin
      n_fail++; $display("FAIL zero_after got %b exp 000", {o_valid, o_done, o_busy});
    end
  endtask

  task automatic test_reset_mid();
    bit saw;
    i_ready = 1'b1;
    do_start(1, 10);
    tick(); tick();
    n_tests++;
    if (o_block !== exp_cnt(2)) begin n_fail++; $display("FAIL rstmid_pre got %h exp %h", o_block, exp_cnt(2)); end
    // Reset on the third transfer, with a competing start request.
    rst = 1'b1; i_start = 1'b1; i_mode = 2'd0; i_num_blocks = 8'd3;
    tick();
    rst = 1'b0; i_start = 1'b0;
    n_tests++;
    if ({o_valid, o_busy, o_done, o_count} !== {3'b000, 8'd0}) begin
      n_fail++; $display("FAIL rstmid_flags got v=%b b=%b d=%b cnt=%0d exp all 0", o_valid, o_busy, o_done, o_count);
    end
    n_tests++;
    if (o_block !== '0) begin n_fail++; $display("FAIL rstmid_block got %h exp 0", o_block); end
    saw = 1'b0;
    repeat (4) begin
      if (o_done || o_valid) saw = 1'b1;
      tick();
    end
    n_tests++;
    if (saw !== 1'b0) begin n_fail++; $display("FAIL rstmid_quiet got activity=%b exp 0", saw); end
    do_start(1, 10);
    for (int c = 0; c < 10; c++) begin
      n_tests++;
      if (o_block !== exp_cnt(c) || o_valid !== 1'b1) begin
        n_fail++; $display("FAIL rstmid_rerun c=%0d got v=%b %h exp %h", c, o_valid, o_block, exp_cnt(c));
      end
      tick();
    end
    n_tests++;
    if ({o_done, o_count} !== {1'b1, 8'd10}) begin
      n_fail++; $display("FAIL rstmid_rerun_done got done=%b count=%0d exp 1 10", o_done, o_count);
    end
    tick();
  endtask

  task automatic test_start_in_run();
    i_ready = 1'b1;
    do_start(0, 5);
    for (int c = 0; c < 5; c++) begin
      n_tests++;
      if (o_block !== exp_cyc(c % 4 + 1) || o_valid !== 1'b1) begin
        n_fail++; $display("FAIL sir_block c=%0d got v=%b %h exp %h", c, o_valid, o_block, exp_cyc(c % 4 + 1));
      end
      if (c == 1) begin
        i_start = 1'b1; i_mode = 2'd3; i_num_blocks = 8'd2;
      end else begin
        i_start = 1'b0;
      end
      tick();
    end
    n_tests++;
    if ({o_done, o_valid, o_count} !== {2'b10, 8'd5}) begin
      n_fail++; $display("FAIL sir_done got done=%b valid=%b count=%0d exp 1 0 5", o_done, o_valid, o_count);
    end
    tick();
    n_tests++;
    if ({o_busy, o_done} !== 2'b00) begin n_fail++; $display("FAIL sir_idle got %b exp 00", {o_busy, o_done}); end
  endtask

  task automatic test_long_idle();
    int xfers, dones;
    xfers = 0; dones = 0;
    i_ready = 1'b1;
    do_start(3, 255);
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (o_done) dones++;
      if (o_valid) begin
        n_tests++;
        if (o_block !== {{PW{1'b0}}, 1'b1}) begin
          n_fail++; $display("FAIL idle_block n=%0d got %h exp 1", xfers, o_block);
        end
        xfers++;
      end
      tick();
    end
    n_tests++;
    if (xfers !== 255) begin n_fail++; $display("FAIL idle_xfers got %0d exp 255", xfers); end
    n_tests++;
    if (dones !== 1) begin n_fail++; $display("FAIL idle_done_pulses got %0d exp 1", dones); end
    n_tests++;
    if (o_count !== 8'd255) begin n_fail++; $display("FAIL idle_count got %0d exp 255", o_count); end
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_mode = 2'd0; i_num_blocks = '0; i_ready = 1'b0;
    // Reference PRBS31 stream from the all-ones seed: b[n] = b[n-31] ^ b[n-28].
    for (int n = 0; n < 1024; n++) begin
      if (n < 31) prbs_ref[n] = 1'b1;
      else        prbs_ref[n] = prbs_ref[n-31] ^ prbs_ref[n-28];
    end
    test_reset();
    test_cyclic();
    test_counter_stall();
    test_prbs();
    test_zero_len();
    test_reset_mid();
    test_start_in_run();
    test_long_idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/block_pattern_gen.md
BLOCK_PATTERN_GEN -- requirements
Module: block_pattern_gen

Interface
REQ-001 SHALL provide parameter BITS_BLOCK, default 257, meaning the width of one transcoded block.
REQ-002 SHALL provide parameter CNT_WIDTH, default 16, meaning the width of the block-count fields.
REQ-003 SHALL provide port clk, input, 1, the single clock for all logic.
REQ-004 SHALL provide port rst, input, 1, reset: synchronous, active-high.
REQ-005 SHALL provide port i_start, input, 1, a start request, sampled only in IDLE.
REQ-006 SHALL provide port i_mode, input, 2, the pattern select, latched at start.
REQ-007 SHALL provide port i_num_blocks, input, CNT_WIDTH, the burst length, latched at start.
REQ-008 SHALL provide port i_ready, input, 1, downstream ready (the flow distributor input side).
REQ-009 SHALL provide port o_block, output, BITS_BLOCK, the generated block.
REQ-010 SHALL provide port o_valid, output, 1, asserted when o_block is valid.
REQ-011 SHALL provide port o_busy, output, 1, high while in RUN.
REQ-012 SHALL provide port o_done, output, 1, a one-cycle burst-complete pulse.
REQ-013 SHALL provide port o_count, output, CNT_WIDTH, the number of blocks transferred in the current or last burst.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE, all registered.
REQ-015 IDLE: on i_start=1 with i_num_blocks!=0, the block SHALL latch mode and length, clear o_count, seed the generator, and go to RUN the next cycle.
REQ-016 IDLE: on i_start=1 with i_num_blocks==0, the block SHALL go to DONE without asserting o_valid.
REQ-017 RUN: o_valid SHALL be 1 and o_busy SHALL be 1; a transfer SHALL occur on any cycle with o_valid=1 and i_ready=1.
REQ-018 On each transfer, o_count SHALL increment by 1 and o_block SHALL advance to the next pattern value in the following cycle.
REQ-019 While o_valid=1 and i_ready=0, o_block SHALL hold stable.
REQ-020 On the transfer that makes o_count equal to the latched length, the block SHALL go to DONE; o_valid SHALL be 0 in the next cycle.
REQ-021 DONE: o_done SHALL be 1 for exactly one cycle, then the block SHALL return to IDLE; o_count SHALL hold until the next start.
REQ-022 i_start SHALL be ignored in RUN and DONE; i_mode and i_num_blocks changes after start SHALL have no effect.
REQ-023 Latency: the first o_valid SHALL occur 1 cycle after i_start is sampled in IDLE.
REQ-024 Mode 0 (cyclic): blocks SHALL cycle k=1,2,3,4,1,... with o_block equal to the 3-bit value k replicated and truncated to the lower BITS_BLOCK bits.
REQ-025 Mode 1 (counter): o_block[0] SHALL be 1 and o_block[BITS_BLOCK-1:1] SHALL be the zero-extended transfer index starting at 0.
REQ-026 Mode 2 (PRBS31): the generator SHALL use polynomial x^31+x^28+1 with seed 31'h7FFFFFFF at start; o_block[0] SHALL be 1 and o_block[BITS_BLOCK-1:1] SHALL be the next BITS_BLOCK-1 PRBS bits, earliest bit in bit 1; the state SHALL advance BITS_BLOCK-1 steps per transfer only.
REQ-027 Mode 3 (idle fill): o_block SHALL equal 1 (header bit set, payload zero) for every block.
REQ-028 The counter SHALL wrap modulo 2^CNT_WIDTH internally, and a length of 2^CNT_WIDTH-1 SHALL complete correctly.

Reset
REQ-029 With rst=1 at a clk edge, the state SHALL become IDLE and o_block=0, o_valid=0, o_busy=0, o_done=0, o_count=0, PRBS state=seed.
REQ-030 Reset asserted mid-RUN SHALL abort the burst with no o_done pulse; rst SHALL take priority over i_start.

Verification
REQ-031 mode=0, num=8, i_ready=1 -> o_valid for 8 consecutive cycles with values {1,2,3,4,1,2,3,4} replicated; o_done 1 cycle after the last transfer; o_count=8.
REQ-032 mode=1, num=4, i_ready toggling 1,0,1,0,... -> indices 0..3 each held through stall cycles; exactly 4 transfers; o_done once.
REQ-033 mode=2, num=2 -> block0[31:1] equals the first 31 PRBS31 bits from the all-ones seed (31 ones); block1 continues the sequence without a gap; o_block[0]=1.
REQ-034 num=0 start -> no o_valid; o_done pulses on the cycle after start; o_count=0.
REQ-035 rst asserted at the 3rd transfer of a 10-block burst -> all outputs 0 in the next cycle, no o_done; a new start runs a full burst from index 0 / seed.
REQ-036 i_start pulsed during RUN with a different mode and length -> ignored; the original burst completes unchanged.
